// File: rtl/cmd_src_q_pkg.sv
// Shared command-format definitions for the per-core outbound command queue.
// The `CMD_* defines mirror the existing defs; the localparams are what RTL uses.
`ifndef CMD_SIZE
`define CMD_SIZE 16
`endif
`ifndef CMD_VALID
`define CMD_VALID 15
`endif
`ifndef CMD_BUS
`define CMD_BUS 0
`endif

package cmd_src_q_pkg;

  localparam int CMD_SIZE  = `CMD_SIZE;
  localparam int CMD_VALID = `CMD_VALID;
  localparam int CMD_BUS   = `CMD_BUS;

  typedef logic [CMD_SIZE-1:0] cmd_t;

  typedef enum logic {
    BUS_0 = 1'b0,
    BUS_1 = 1'b1
  } bus_e;

  // Replace the valid bit of a command word, leaving the payload untouched.
  function automatic cmd_t cmd_with_valid(cmd_t c, logic v);
    cmd_t r;
    r            = c;
    r[CMD_VALID] = v;
    return r;
  endfunction

endpackage

// File: rtl/cmd_src_if.sv
// Core/arbiter-facing signal bundle of one command source queue.
// master = core + arbiter side driving requests/strobes, slave = the queue.
interface cmd_src_if #(
  parameter int DEPTH = 4
);
  import cmd_src_q_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic          req_val;
  cmd_t          req_cmd;
  logic          req_rdy;
  logic [1:0]    stall;
  logic [1:0]    cmd_tkn;
  cmd_t          cmd_out_0;
  cmd_t          cmd_out_1;
  logic [CW-1:0] cnt_0;
  logic [CW-1:0] cnt_1;
  logic          err;

  modport master (
    output req_val, req_cmd, stall, cmd_tkn,
    input  req_rdy, cmd_out_0, cmd_out_1, cnt_0, cnt_1, err
  );

  modport slave (
    input  req_val, req_cmd, stall, cmd_tkn,
    output req_rdy, cmd_out_0, cmd_out_1, cnt_0, cnt_1, err
  );

endinterface

// File: rtl/cmd_src_q_fifo.sv
// Single-bus command FIFO: circular buffer with registered pointers and count.
// Head is read combinationally from storage so a pushed entry shows next cycle.
module cmd_src_fifo
  import cmd_src_q_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  cmd_t                   din,
  input  logic                   pop,
  output cmd_t                   head,
  output logic [$clog2(DEPTH):0] cnt,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Guard locally as well, so a misbehaving parent cannot corrupt the ring.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & (cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  assign head = mem[rd_ptr];
  assign full = (cnt == CW'(DEPTH));

endmodule

// File: rtl/cmd_src_q.sv
// Per-core outbound command queue: steers core commands into two per-bus
// FIFOs and presents each head to the node command arbiter.
module cmd_src_q
  import cmd_src_q_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int BUS_BIT = CMD_BUS
) (
  input logic      clk,
  input logic      rst,
  cmd_src_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cmd_src_q: DEPTH must be a power of 2 in 2..16");
  end
  if (BUS_BIT == CMD_VALID || BUS_BIT < 0 || BUS_BIT >= CMD_SIZE) begin : g_bad_bus_bit
    $error("cmd_src_q: BUS_BIT must index the command and differ from CMD_VALID");
  end

  bus_e          bus_sel;
  cmd_t          wr_cmd;
  logic          wr_en;
  logic          push_0;
  logic          push_1;
  logic          pop_0;
  logic          pop_1;
  logic          full_0;
  logic          full_1;
  cmd_t          head_0;
  cmd_t          head_1;
  logic [CW-1:0] cnt_0;
  logic [CW-1:0] cnt_1;
  logic          vld_0;
  logic          vld_1;
  logic          bad_tkn;
  logic          err_q;

  // Handshakes: a command moves on a clock edge where req_val & req_rdy;
  // req_rdy depends only on req_cmd's bus bit and that bus's count (never on
  // cmd_tkn), so a full FIFO refuses even when it is being popped. On the
  // arbiter side a head moves when cmd_tkn[b] & cmd_out_b valid; a strobe
  // against an invalid head is a protocol error and is otherwise ignored.
  assign bus_sel     = bus_e'(bus.req_cmd[BUS_BIT]);
  assign bus.req_rdy = (bus_sel == BUS_1) ? ~full_1 : ~full_0;
  assign wr_en       = bus.req_val & bus.req_rdy;
  assign push_0      = wr_en & (bus_sel == BUS_0);
  assign push_1      = wr_en & (bus_sel == BUS_1);
  assign wr_cmd      = cmd_with_valid(bus.req_cmd, 1'b1);

  // stall hides a head from the arbiter without touching its payload.
  assign vld_0 = (cnt_0 != '0) & ~bus.stall[0];
  assign vld_1 = (cnt_1 != '0) & ~bus.stall[1];

  assign pop_0   = bus.cmd_tkn[0] & vld_0;
  assign pop_1   = bus.cmd_tkn[1] & vld_1;
  assign bad_tkn = |(bus.cmd_tkn & ~{vld_1, vld_0});

  cmd_src_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo_0 (
    .clk  (clk),
    .rst  (rst),
    .push (push_0),
    .din  (wr_cmd),
    .pop  (pop_0),
    .head (head_0),
    .cnt  (cnt_0),
    .full (full_0)
  );

  cmd_src_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo_1 (
    .clk  (clk),
    .rst  (rst),
    .push (push_1),
    .din  (wr_cmd),
    .pop  (pop_1),
    .head (head_1),
    .cnt  (cnt_1),
    .full (full_1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (bad_tkn) begin
      err_q <= 1'b1;
    end
  end

  assign bus.cmd_out_0 = cmd_with_valid(head_0, vld_0);
  assign bus.cmd_out_1 = cmd_with_valid(head_1, vld_1);
  assign bus.cnt_0     = cnt_0;
  assign bus.cnt_1     = cnt_1;
  assign bus.err       = err_q;

endmodule

// File: doc/cmd_src_q.md
Name: cmd_src_q

Overview:
- Per-core outbound command queue: the producer end of the node command arbiter interface.
- Accepts commands from the core via a valid/ready handshake and steers each into one of two per-bus FIFOs.
- Presents each FIFO head to the arbiter on cmd_out_0/cmd_out_1 and pops on the arbiter's cmd_tkn strobes.
- One instance per core; four instances feed the arbiter's cmd_in_{0,1}_{0..3} / cmd_tkn_{0..3} ports.

Parameters:
- DEPTH, 4, entries per bus FIFO; power of 2, range 2..16.
- BUS_BIT, 0, bit index within the command that selects the bus (0 -> bus 0, 1 -> bus 1); must not equal `CMD_VALID.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- req_val  in  1  core has a command on req_cmd.
- req_cmd  in  `CMD_SIZE  command from core; the `CMD_VALID bit is ignored on input.
- req_rdy  out  1  target FIFO (chosen by req_cmd[BUS_BIT]) can accept.
- stall  in  2  per-bus hold-off from smp/address-compare logic; bit b masks the valid on bus b.
- cmd_tkn  in  2  arbiter taken strobes; bit b pops the bus b head.
- cmd_out_0  out  `CMD_SIZE  bus 0 head toward the arbiter.
- cmd_out_1  out  `CMD_SIZE  bus 1 head toward the arbiter.
- cnt_0  out  $clog2(DEPTH)+1  bus 0 occupancy.
- cnt_1  out  $clog2(DEPTH)+1  bus 1 occupancy.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst=0, asynchronous):
  - read/write pointers and counts go to 0; err goes to 0.
  - cmd_out_b[`CMD_VALID]=0; the remaining cmd_out bits are don't-care.
  - req_rdy=1.
- Enqueue:
  - A write occurs when req_val & req_rdy at the clock edge.
  - Target bus b = req_cmd[BUS_BIT]; the entry is stored with `CMD_VALID forced to 1.
  - req_rdy = !full_b for the bus selected by the current req_cmd. It is combinational from req_cmd and the count; there is no path from cmd_tkn.
  - A full FIFO refuses the write even when cmd_tkn pops it in the same cycle.
- Presentation:
  - cmd_out_b = head entry of FIFO b, read combinationally from storage.
  - cmd_out_b[`CMD_VALID] = (cnt_b != 0) & ~stall[b].
  - Latency: a command written at edge N is visible as valid from cycle N+1 when the FIFO was empty.
  - The head stays stable until popped. stall only masks the valid bit and never alters the payload.
- Pop:
  - On cmd_tkn[b] & cmd_out_b[`CMD_VALID]: advance rd_ptr_b (modulo DEPTH) and decrement cnt_b.
  - The next entry is presented in the following cycle.
- Simultaneous write and pop on the same bus: both take effect and cnt_b is unchanged. On an empty FIFO, the pop side is invalid (see err).
- Writes and pops on different buses are fully independent.
- Pointers are log2(DEPTH) bits and wrap naturally. cnt_b ranges 0..DEPTH; full_b = (cnt_b==DEPTH).
- Ordering: FIFO order is kept per bus only. No ordering is guaranteed between buses.
- err is set, and held until reset, when cmd_tkn[b] arrives while cmd_out_b[`CMD_VALID]==0 (empty or stalled).
  - An illegal strobe has no effect on pointers or counts.
- Reset mid-operation discards all queued entries; the valids drop asynchronously on rst assertion.
- Deassertion of rst is synchronised upstream; the block needs no synchroniser.

Decomposition:
- Shared package/defs: `CMD_SIZE and `CMD_VALID (existing defs.v). Add a `CMD_BUS bit-index define as the default for BUS_BIT.
- Sub-module cmd_src_fifo:
  - one DEPTH x `CMD_SIZE FIFO with push, pop, head, cnt and full outputs;
  - instantiated twice, with the steering, stall masking and err logic in the top.

Test Plan:
1. Reset, then push cmd A (BUS_BIT=0) -> cycle after push: cmd_out_0 valid with payload A, cmd_out_1 invalid, cnt_0=1; tkn[0] -> cnt_0=0 and valid drops next cycle.
2. DEPTH=4: push 4 bus-1 cmds B0..B3 with no tkn -> cnt_1=4 and req_rdy=0 for a bus-1 request, while req_rdy=1 for a bus-0 request. Pop all 4 via tkn[1] -> out order B0,B1,B2,B3; push B4 -> wraps to slot 0 and presents correctly.
3. cnt_0=2, simultaneous push and tkn[0] -> cnt_0 stays 2; the head advances to the second entry; the new entry lands at the tail.
4. Head valid on bus 0, stall[0]=1 for 3 cycles -> cmd_out_0 valid=0 with payload unchanged; release -> valid=1 with the same payload. tkn[0] during stall -> err=1, cnt_0 unchanged.
5. tkn[1] with FIFO 1 empty -> err=1 and stays 1 until rst; cnt_1 remains 0.
6. Both FIFOs hold 2 entries; assert rst=0 asynchronously mid-cycle -> both valids drop immediately, cnt_0=cnt_1=0, req_rdy=1; after release, the first push presents fresh data.
